// File: rtl/alu_step_if.sv
// Operator-panel bus for alu_step_sequencer: switch/button inputs plus the register,
// flag and display-select outputs.
interface alu_step_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] data_i;
  logic             op_i;
  logic             step_i;
  logic             abort_i;
  logic [WIDTH-1:0] op_a_o;
  logic [WIDTH-1:0] op_b_o;
  logic [WIDTH-1:0] result_o;
  logic             carry_o;
  logic             overflow_o;
  logic             zero_o;
  logic [2:0]       state_o;
  logic             busy_o;
  logic             done_o;
  logic [1:0]       disp_sel_o;

  modport master (
    output data_i, op_i, step_i, abort_i,
    input  op_a_o, op_b_o, result_o, carry_o, overflow_o, zero_o,
           state_o, busy_o, done_o, disp_sel_o
  );

  modport slave (
    input  data_i, op_i, step_i, abort_i,
    output op_a_o, op_b_o, result_o, carry_o, overflow_o, zero_o,
           state_o, busy_o, done_o, disp_sel_o
  );
endinterface

// File: rtl/alu_step_sequencer.sv
// Step-button sequencer for the add/subtract datapath: load A, load B, execute, show.
// Optional ACC_CHAIN_EN: a step in SHOW feeds Result back into OpA and jumps to LOAD_B.
module alu_step_sequencer #(
  parameter int WIDTH       = 16,
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  alu_step_if.slave  bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_SHOW   = 3'd4;
  localparam logic [3:0] CNT_LAST = 4'(EXEC_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
  logic             carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
  logic             op_q, op_d, done_q, done_d, step_q;
  logic [3:0]       cnt_q, cnt_d;
  logic             step_edge;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             sum_ovf;

  assign step_edge = bus.step_i & ~step_q;

  // Subtract is A + ~B + 1, so carry-out means "no borrow".
  assign b_eff   = op_q ? ~op_b_q : op_b_q;
  assign sum     = {1'b0, op_a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_q};
  assign sum_ovf = (op_a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                   (sum[WIDTH-1] != op_a_q[WIDTH-1]);

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    if (bus.abort_i) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE:   if (step_edge) state_d = S_LOAD_A;
        S_LOAD_A: if (step_edge) begin
          op_a_d  = bus.data_i;
          state_d = S_LOAD_B;
        end
        S_LOAD_B: if (step_edge) begin
          op_b_d  = bus.data_i;
          op_d    = bus.op_i;
          cnt_d   = 4'd0;
          state_d = S_EXEC;
        end
        S_EXEC: begin
          // Step edges are deliberately not looked at here: presses in EXEC are dropped.
          if (cnt_q == CNT_LAST) begin
            result_d = sum[WIDTH-1:0];
            carry_d  = sum[WIDTH];
            ovf_d    = sum_ovf;
            zero_d   = (sum[WIDTH-1:0] == '0);
            done_d   = 1'b1;
            cnt_d    = 4'd0;
            state_d  = S_SHOW;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_SHOW: if (step_edge) begin
`ifdef ACC_CHAIN_EN
          op_a_d  = result_q;
          state_d = S_LOAD_B;
`else
          state_d = S_LOAD_A;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      op_q     <= 1'b0;
      cnt_q    <= 4'd0;
      done_q   <= 1'b0;
      step_q   <= 1'b1;  // a button held through reset must not look like a press
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      step_q   <= bus.step_i;
    end
  end

  // Display select is a pure decode of the state, so IDLE shows the Result.
  always_comb begin
    case (state_q)
      S_IDLE:   bus.disp_sel_o = 2'd3;
      S_LOAD_A: bus.disp_sel_o = 2'd0;
`ifdef ACC_CHAIN_EN
      S_LOAD_B: bus.disp_sel_o = 2'd1;
`else
      S_LOAD_B: bus.disp_sel_o = 2'd0;
`endif
      S_EXEC:   bus.disp_sel_o = 2'd2;
      S_SHOW:   bus.disp_sel_o = 2'd3;
      default:  bus.disp_sel_o = 2'd0;
    endcase
  end

  assign bus.op_a_o     = op_a_q;
  assign bus.op_b_o     = op_b_q;
  assign bus.result_o   = result_q;
  assign bus.carry_o    = carry_q;
  assign bus.overflow_o = ovf_q;
  assign bus.zero_o     = zero_q;
  assign bus.state_o    = state_q;
  assign bus.busy_o     = (state_q == S_EXEC);
  assign bus.done_o     = done_q;
endmodule
